// File: rtl/imem_ctrl.sv
// ---------------------------------------------------------------------------
// imem_ctrl -- instruction RAM owner / arbiter
//
// Purpose:
//   Owns the single-port instruction RAM and arbitrates IF-stage fetches
//   against loader writes coming from the host/debug bridge. A LOAD -> DRAIN
//   -> RUN state machine holds the core while a program is written, then hands
//   the RAM to fetch. In RUN, fetch has priority. A starvation counter makes
//   sure the loader still makes progress, so code can be patched while the
//   core is running.
//
// Optional feature (compile-time macro):
//   IMEM_MISALIGN_EN  defined   : a granted fetch with fetch_addr[1:0] != 0
//                                 raises fetch_misal alongside fetch_valid,
//                                 and fetch_rdata is forced to NOP. The RAM
//                                 read is still issued.
//                     undefined : fetch_misal is tied 0; the low address
//                                 bits are ignored.
//
// Parameters:
//   DEPTH        RAM depth in 32-bit words
//   AW           word-address width, = clog2(DEPTH)
//   STARVE_MAX   max consecutive blocked loader cycles in RUN (>= 1)
//   BOOT_ON_RST  1: leave reset in LOAD; 0: leave reset in RUN
//
// Ports:
//   clk, rst_n             clock (rising edge), async active-low reset
//   boot_req               level request to enter LOAD
//   ld_done                pulse, program load complete
//   ld_valid/addr/data     loader write request (byte address)
//   ld_ready               loader write accepted this cycle
//   fetch_req/fetch_addr   IF fetch request (byte address = PC)
//   fetch_stall            fetch not granted this cycle, IF holds PC
//   fetch_valid/rdata      fetched word, one cycle after the grant
//   fetch_misal            misaligned fetch flag
//   cpu_hold               hold the pipeline
//   mem_en/we/addr/wdata   RAM control (word address)
//   mem_rdata              RAM read data, registered, 1-cycle latency
// ---------------------------------------------------------------------------
module imem_ctrl #(
  parameter int unsigned DEPTH       = 256,
  parameter int unsigned AW          = 8,
  parameter int unsigned STARVE_MAX  = 4,
  parameter int unsigned BOOT_ON_RST = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          boot_req,
  input  logic          ld_done,
  input  logic          ld_valid,
  input  logic [31:0]   ld_addr,
  input  logic [31:0]   ld_data,
  output logic          ld_ready,
  input  logic          fetch_req,
  input  logic [31:0]   fetch_addr,
  output logic          fetch_stall,
  output logic          fetch_valid,
  output logic [31:0]   fetch_rdata,
  output logic          fetch_misal,
  output logic          cpu_hold,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [31:0]   mem_wdata,
  input  logic [31:0]   mem_rdata
);

  localparam logic [31:0] NOP   = 32'h0000_0013;
  localparam logic [31:0] LIMIT = 32'(DEPTH * 4);
  localparam int unsigned SW    = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);

  typedef enum logic [1:0] {
    ST_LOAD,
    ST_DRAIN,
    ST_RUN
  } state_t;

  localparam state_t RST_STATE = (BOOT_ON_RST != 0) ? ST_LOAD : ST_RUN;

  state_t        r_state;
  logic [SW-1:0] r_starve;
  logic          r_rd_pend;
  logic          r_rd_oor;
  logic          r_boot_pend;
`ifdef IMEM_MISALIGN_EN
  logic          r_rd_mis;
`endif

  logic w_fetch_inr;
  logic w_ld_inr;
  logic w_starved;
  logic w_fetch_blk;
  logic w_fetch_gnt;
  logic w_ld_gnt;
  logic w_ld_blocked;
  logic w_rd_nop;

  assign w_fetch_inr = (fetch_addr < LIMIT);
  assign w_ld_inr    = (ld_addr < LIMIT);
  assign w_starved   = ld_valid && (r_starve == SW'(STARVE_MAX));

  // A boot request arriving while a read is in flight waits one cycle for
  // that read to retire; no new fetch may slip in during that window.
  assign w_fetch_blk = r_boot_pend || (boot_req && r_rd_pend);

  assign w_fetch_gnt  = (r_state == ST_RUN) && fetch_req && !w_starved && !w_fetch_blk;
  assign w_ld_gnt     = ld_valid && ((r_state == ST_LOAD) ||
                                     ((r_state == ST_RUN) && !w_fetch_gnt));
  assign w_ld_blocked = (r_state == ST_RUN) && ld_valid && !w_ld_gnt;

`ifdef IMEM_MISALIGN_EN
  assign w_rd_nop    = r_rd_oor || r_rd_mis;
  assign fetch_misal = r_rd_pend && r_rd_mis;
`else
  assign w_rd_nop    = r_rd_oor;
  assign fetch_misal = 1'b0;
`endif

  assign cpu_hold    = (r_state != ST_RUN);
  assign fetch_valid = r_rd_pend;

  always_comb begin
    fetch_rdata = '0;
    if (r_rd_pend) begin
      fetch_rdata = w_rd_nop ? NOP : mem_rdata;
    end
  end

  always_comb begin
    ld_ready    = 1'b0;
    fetch_stall = 1'b0;
    unique case (r_state)
      ST_LOAD: begin
        ld_ready    = 1'b1;
        fetch_stall = 1'b1;
      end
      ST_DRAIN: begin
        fetch_stall = 1'b1;
      end
      ST_RUN: begin
        ld_ready    = w_ld_gnt;
        fetch_stall = fetch_req && !w_fetch_gnt;
      end
      default: begin
        ld_ready    = 1'b0;
        fetch_stall = 1'b1;
      end
    endcase
  end

  // Out-of-range accesses still complete their handshake but never touch
  // the RAM.
  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (w_fetch_gnt && w_fetch_inr) begin
      mem_en   = 1'b1;
      mem_addr = fetch_addr[AW+1:2];
    end else if (w_ld_gnt && w_ld_inr) begin
      mem_en    = 1'b1;
      mem_we    = 1'b1;
      mem_addr  = ld_addr[AW+1:2];
      mem_wdata = ld_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= RST_STATE;
      r_starve    <= '0;
      r_rd_pend   <= 1'b0;
      r_rd_oor    <= 1'b0;
      r_boot_pend <= 1'b0;
`ifdef IMEM_MISALIGN_EN
      r_rd_mis    <= 1'b0;
`endif
    end else begin
      r_rd_pend <= w_fetch_gnt;
      r_rd_oor  <= w_fetch_gnt && !w_fetch_inr;
`ifdef IMEM_MISALIGN_EN
      r_rd_mis  <= w_fetch_gnt && (fetch_addr[1:0] != 2'b00);
`endif

      if (w_ld_blocked) begin
        r_starve <= r_starve + SW'(1);
      end else begin
        r_starve <= '0;
      end

      unique case (r_state)
        ST_LOAD: begin
          // ld_done wins over a concurrent boot_req.
          if (ld_done) begin
            r_state <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          r_state <= ST_RUN;
        end
        ST_RUN: begin
          if (r_boot_pend) begin
            r_boot_pend <= 1'b0;
            r_state     <= ST_LOAD;
          end else if (boot_req) begin
            if (r_rd_pend) begin
              r_boot_pend <= 1'b1;
            end else begin
              r_state <= ST_LOAD;
            end
          end
        end
        default: begin
          r_state <= RST_STATE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_imem_ctrl.sv
module tb_imem_ctrl;

  localparam int unsigned DEPTH      = 256;
  localparam int unsigned AW         = 8;
  localparam int unsigned STARVE_MAX = 4;
  localparam logic [31:0] NOP        = 32'h0000_0013;
  localparam logic [31:0] LIMIT      = 32'(DEPTH * 4);
`ifdef IMEM_MISALIGN_EN
  localparam bit MIS = 1'b1;
`else
  localparam bit MIS = 1'b0;
`endif

  localparam logic [31:0] WA = 32'hA1A1_0001;
  localparam logic [31:0] WB = 32'hB2B2_0002;
  localparam logic [31:0] WC = 32'hC3C3_0003;
  localparam logic [31:0] WD = 32'hD4D4_0004;
  localparam logic [31:0] WE = 32'hE5E5_0005;
  localparam logic [31:0] WF = 32'hF6F6_0006;
  localparam logic [31:0] WS = 32'h5555_AAAA;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          boot_req = 1'b0;
  logic          ld_done = 1'b0;
  logic          ld_valid = 1'b0;
  logic [31:0]   ld_addr = '0;
  logic [31:0]   ld_data = '0;
  logic          ld_ready;
  logic          fetch_req = 1'b0;
  logic [31:0]   fetch_addr = '0;
  logic          fetch_stall;
  logic          fetch_valid;
  logic [31:0]   fetch_rdata;
  logic          fetch_misal;
  logic          cpu_hold;
  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic [31:0]   mem_rdata;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  imem_ctrl #(
    .DEPTH(DEPTH),
    .AW(AW),
    .STARVE_MAX(STARVE_MAX),
    .BOOT_ON_RST(1)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .boot_req(boot_req),
    .ld_done(ld_done),
    .ld_valid(ld_valid),
    .ld_addr(ld_addr),
    .ld_data(ld_data),
    .ld_ready(ld_ready),
    .fetch_req(fetch_req),
    .fetch_addr(fetch_addr),
    .fetch_stall(fetch_stall),
    .fetch_valid(fetch_valid),
    .fetch_rdata(fetch_rdata),
    .fetch_misal(fetch_misal),
    .cpu_hold(cpu_hold),
    .mem_en(mem_en),
    .mem_we(mem_we),
    .mem_addr(mem_addr),
    .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  // Single-port RAM with registered read.
  logic [31:0] ram [DEPTH];
  logic [31:0] ram_q;
  always_ff @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) ram[mem_addr] <= mem_wdata;
      else        ram_q <= ram[mem_addr];
    end
  end
  assign mem_rdata = ram_q;

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endfunction

  typedef struct {
    bit          boot, done, lv;
    logic [31:0] la, ld;
    bit          fr;
    logic [31:0] fa;
    bit          x_ldr, x_stall, x_hold, x_en, x_we;
    int unsigned x_maddr;
    bit          x_valid;
    logic [31:0] x_rdata;
    bit          x_mis;
  } vec_t;

  function automatic vec_t mk(input bit boot, input bit done, input bit lv,
                              input logic [31:0] la, input logic [31:0] ld,
                              input bit fr, input logic [31:0] fa,
                              input bit ldr, input bit stall, input bit hold,
                              input bit en, input bit we, input int unsigned maddr,
                              input bit valid, input logic [31:0] rdata, input bit mis);
    vec_t v;
    v.boot = boot; v.done = done; v.lv = lv; v.la = la; v.ld = ld;
    v.fr = fr; v.fa = fa;
    v.x_ldr = ldr; v.x_stall = stall; v.x_hold = hold; v.x_en = en; v.x_we = we;
    v.x_maddr = maddr; v.x_valid = valid; v.x_rdata = rdata; v.x_mis = mis;
    return v;
  endfunction

  task automatic drive_idle();
    boot_req = 1'b0; ld_done = 1'b0; ld_valid = 1'b0; ld_addr = '0; ld_data = '0;
    fetch_req = 1'b0; fetch_addr = '0;
  endtask

  task automatic apply_vec(input vec_t v, input string tag);
    @(negedge clk);
    boot_req = v.boot; ld_done = v.done; ld_valid = v.lv; ld_addr = v.la; ld_data = v.ld;
    fetch_req = v.fr; fetch_addr = v.fa;
    #2;
    check({tag, ".ld_ready"}, ld_ready, v.x_ldr);
    if (v.fr) check({tag, ".fetch_stall"}, fetch_stall, v.x_stall);
    check({tag, ".cpu_hold"}, cpu_hold, v.x_hold);
    check({tag, ".mem_en"}, mem_en, v.x_en);
    check({tag, ".mem_we"}, mem_we, v.x_we);
    if (v.x_en) check({tag, ".mem_addr"}, 32'(mem_addr), v.x_maddr);
    if (v.x_we) check({tag, ".mem_wdata"}, mem_wdata, v.ld);
    check({tag, ".fetch_valid"}, fetch_valid, v.x_valid);
    check({tag, ".fetch_rdata"}, fetch_rdata, v.x_rdata);
    check({tag, ".fetch_misal"}, fetch_misal, v.x_mis);
  endtask

  task automatic pulse_reset(input string tag);
    @(negedge clk);
    drive_idle();
    rst_n = 1'b0;
    #2;
    check({tag, ".cpu_hold"}, cpu_hold, 1);
    check({tag, ".ld_ready"}, ld_ready, 1);
    check({tag, ".fetch_valid"}, fetch_valid, 0);
    check({tag, ".fetch_rdata"}, fetch_rdata, 0);
    check({tag, ".fetch_misal"}, fetch_misal, 0);
    check({tag, ".mem_en"}, mem_en, 0);
    check({tag, ".mem_we"}, mem_we, 0);
    #2 rst_n = 1'b1;
  endtask

  // Reference model: spec-level bookkeeping of mode, loader starvation and
  // the expected contents of every RAM word.
  bit          m_load, m_drain, m_boot_wait;
  int          m_starve;
  bit          m_pend, m_pknown, m_pmis;
  logic [31:0] m_pdata;
  logic [31:0] ref_mem   [DEPTH];
  bit          ref_known [DEPTH];

  function automatic void model_reset();
    m_load = 1'b1; m_drain = 1'b0; m_boot_wait = 1'b0; m_starve = 0;
    m_pend = 1'b0; m_pknown = 1'b0; m_pmis = 1'b0; m_pdata = '0;
  endfunction

  function automatic logic [31:0] rand_addr();
    int unsigned r = $urandom_range(0, 19);
    logic [31:0] a = 32'($urandom_range(0, 15)) << 2;
    if (r == 0)      a = 32'h400 + a;
    else if (r == 1) a = $urandom;
    else if (r <= 4) a = a | 32'($urandom_range(1, 3));
    return a;
  endfunction

  vec_t tbl [19];
  vec_t v;

  initial begin
    tbl[0]  = mk(0,0,1, 32'h0,   WA, 0, 32'h0,   1,0,1, 1,1,0, 0,32'h0,0);
    tbl[1]  = mk(0,0,1, 32'h4,   WB, 0, 32'h0,   1,0,1, 1,1,1, 0,32'h0,0);
    tbl[2]  = mk(0,0,1, 32'h8,   WC, 1, 32'h0,   1,1,1, 1,1,2, 0,32'h0,0);
    tbl[3]  = mk(1,1,1, 32'hC,   WD, 0, 32'h0,   1,0,1, 1,1,3, 0,32'h0,0);
    tbl[4]  = mk(0,0,1, 32'h10,  WF, 0, 32'h0,   0,0,1, 0,0,0, 0,32'h0,0);
    tbl[5]  = mk(0,0,0, 32'h0,   0,  1, 32'h4,   0,0,0, 1,0,1, 0,32'h0,0);
    tbl[6]  = mk(0,0,0, 32'h0,   0,  1, 32'h8,   0,0,0, 1,0,2, 1,WB,0);
    tbl[7]  = mk(0,0,0, 32'h0,   0,  0, 32'h0,   0,0,0, 0,0,0, 1,WC,0);
    tbl[8]  = mk(0,0,0, 32'h0,   0,  0, 32'h0,   0,0,0, 0,0,0, 0,32'h0,0);
    tbl[9]  = mk(0,0,0, 32'h0,   0,  1, 32'h400, 0,0,0, 0,0,0, 0,32'h0,0);
    tbl[10] = mk(0,0,1, 32'h400, WE, 0, 32'h0,   1,0,0, 0,0,0, 1,NOP,0);
    tbl[11] = mk(0,0,0, 32'h0,   0,  1, 32'h6,   0,0,0, 1,0,1, 0,32'h0,0);
    tbl[12] = mk(0,0,0, 32'h0,   0,  0, 32'h0,   0,0,0, 0,0,0, 1,(MIS ? NOP : WB),MIS);
    tbl[13] = mk(1,0,0, 32'h0,   0,  1, 32'h0,   0,0,0, 1,0,0, 0,32'h0,0);
    tbl[14] = mk(0,0,0, 32'h0,   0,  0, 32'h0,   1,0,1, 0,0,0, 1,WA,0);
    tbl[15] = mk(0,1,1, 32'h10,  WE, 0, 32'h0,   1,0,1, 1,1,4, 0,32'h0,0);
    tbl[16] = mk(0,0,0, 32'h0,   0,  0, 32'h0,   0,0,1, 0,0,0, 0,32'h0,0);
    tbl[17] = mk(0,0,0, 32'h0,   0,  1, 32'h10,  0,0,0, 1,0,4, 0,32'h0,0);
    tbl[18] = mk(0,0,0, 32'h0,   0,  0, 32'h0,   0,0,0, 0,0,0, 1,WE,0);

    drive_idle();
    pulse_reset("reset");

    for (int i = 0; i < 19; i++) apply_vec(tbl[i], $sformatf("tbl%0d", i));

    // Loader starvation: fetch wins STARVE_MAX times, then the loader.
    for (int k = 0; k < 6; k++) begin
      if (k < 4)
        v = mk(0,0,1, 32'h20, WS, 1, 32'h0, 0,0,0, 1,0,0, (k > 0), (k > 0) ? WA : 32'h0, 0);
      else if (k == 4)
        v = mk(0,0,1, 32'h20, WS, 1, 32'h0, 1,1,0, 1,1,8, 1, WA, 0);
      else
        v = mk(0,0,1, 32'h20, WS, 1, 32'h0, 0,0,0, 1,0,0, 0, 32'h0, 0);
      apply_vec(v, $sformatf("starve%0d", k));
    end
    apply_vec(mk(0,0,0, 32'h0, 0, 0, 32'h0, 0,0,0, 0,0,0, 1,WA,0), "starve6");

    // boot_req while a read is in flight: one blocked cycle, then LOAD.
    apply_vec(mk(0,0,0, 32'h0, 0, 1, 32'h4, 0,0,0, 1,0,1, 0,32'h0,0), "bootp_a");
    apply_vec(mk(1,0,0, 32'h0, 0, 1, 32'h8, 0,1,0, 0,0,0, 1,WB,0),    "bootp_b");
    apply_vec(mk(1,0,0, 32'h0, 0, 1, 32'h8, 0,1,0, 0,0,0, 0,32'h0,0), "bootp_c");
    apply_vec(mk(0,0,0, 32'h0, 0, 0, 32'h0, 1,0,1, 0,0,0, 0,32'h0,0), "bootp_d");

    pulse_reset("rst_load");
    apply_vec(mk(0,1,0, 32'h0, 0, 0, 32'h0, 1,0,1, 0,0,0, 0,32'h0,0), "rst_e");
    apply_vec(mk(0,0,0, 32'h0, 0, 0, 32'h0, 0,0,1, 0,0,0, 0,32'h0,0), "rst_f");
    apply_vec(mk(0,0,0, 32'h0, 0, 1, 32'h0, 0,0,0, 1,0,0, 0,32'h0,0), "rst_g");
    pulse_reset("rst_run");
    apply_vec(mk(0,0,0, 32'h0, 0, 0, 32'h0, 1,0,1, 0,0,0, 0,32'h0,0), "rst_h");

    // Randomized run against the reference model.
    model_reset();
    for (int i = 0; i < DEPTH; i++) ref_known[i] = 1'b0;

    for (int cyc = 0; cyc < 3000; cyc++) begin
      bit boot, done, lv, fr, run, blk, fg, lg, e_ldr, e_stall, e_hold, e_we, e_en;
      logic [31:0] la, ld, fa;
      logic [AW-1:0] e_maddr;

      if ($urandom_range(0, 249) == 0) begin
        pulse_reset($sformatf("rnd_rst%0d", cyc));
        model_reset();
        continue;
      end

      boot = ($urandom_range(0, 39) == 0);
      done = ($urandom_range(0, 7) == 0);
      lv   = ($urandom_range(0, 1) == 0);
      fr   = ($urandom_range(0, 9) < 7);
      la   = rand_addr();
      ld   = $urandom;
      fa   = rand_addr();

      @(negedge clk);
      boot_req = boot; ld_done = done; ld_valid = lv; ld_addr = la; ld_data = ld;
      fetch_req = fr; fetch_addr = fa;
      #2;

      run = !m_load && !m_drain;
      fg = 1'b0; lg = 1'b0;
      if (m_load) begin
        e_hold = 1'b1; e_ldr = 1'b1; e_stall = 1'b1; lg = lv;
      end else if (m_drain) begin
        e_hold = 1'b1; e_ldr = 1'b0; e_stall = 1'b1;
      end else begin
        blk = m_boot_wait || (boot && m_pend);
        fg  = fr && !blk && !(lv && m_starve >= STARVE_MAX);
        lg  = lv && !fg;
        e_hold = 1'b0; e_ldr = lg; e_stall = fr && !fg;
      end
      e_we    = lg && (la < LIMIT);
      e_en    = e_we || (fg && (fa < LIMIT));
      e_maddr = fg ? fa[AW+1:2] : la[AW+1:2];

      check("rnd.ld_ready", ld_ready, e_ldr);
      if (fr) check("rnd.fetch_stall", fetch_stall, e_stall);
      check("rnd.cpu_hold", cpu_hold, e_hold);
      check("rnd.mem_en", mem_en, e_en);
      check("rnd.mem_we", mem_we, e_we);
      if (e_en) check("rnd.mem_addr", 32'(mem_addr), 32'(e_maddr));
      if (e_we) check("rnd.mem_wdata", mem_wdata, ld);
      check("rnd.fetch_valid", fetch_valid, m_pend);
      check("rnd.fetch_misal", fetch_misal, m_pend && m_pmis);
      if (!m_pend)      check("rnd.fetch_rdata", fetch_rdata, 32'h0);
      else if (m_pknown) check("rnd.fetch_rdata", fetch_rdata, m_pdata);

      // Advance the model to the next cycle.
      if (m_load) begin
        if (done) begin m_load = 1'b0; m_drain = 1'b1; end
      end else if (m_drain) begin
        m_drain = 1'b0;
      end else if (m_boot_wait) begin
        m_boot_wait = 1'b0; m_load = 1'b1;
      end else if (boot) begin
        if (m_pend) m_boot_wait = 1'b1;
        else        m_load = 1'b1;
      end

      if (run && lv && !lg) m_starve++;
      else                  m_starve = 0;

      m_pend = fg;
      if (fg) begin
        m_pmis = MIS && (fa[1:0] != 2'b00);
        if (fa >= LIMIT || m_pmis) begin
          m_pdata = NOP; m_pknown = 1'b1;
        end else begin
          m_pdata = ref_mem[fa[AW+1:2]]; m_pknown = ref_known[fa[AW+1:2]];
        end
      end else begin
        m_pmis = 1'b0;
      end

      if (lg && la < LIMIT) begin
        ref_mem[la[AW+1:2]]   = ld;
        ref_known[la[AW+1:2]] = 1'b1;
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
